sdram_port_arbiter: RTL and testbench

// - Round-robin arbiter that shares one Avalon-MM master port between two FPGA requesters
//   (m0 = button event logger, m1 = frame/pattern writer); the port feeds the HPS FPGA-to-SDRAM bridge.
// - Forwards single-beat reads and writes. Tags each accepted read with the requester ID and routes
//   the pipelined readdata back to that requester. No bursts.

---
 rtl/sdram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one Avalon-MM master port.
// Accepted reads are tagged with the requester ID so pipelined readdatavalid can be routed back.
//
// state | meaning
// IDLE  | no grant; both requesters stalled, shared port strobes low
// GNT0  | m0 owns the shared port
// GNT1  | m1 owns the shared port
module sdram_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                err_o
);
    localparam int PTR_W = $clog2(MAX_PEND);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic [MAX_PEND-1:0] tag_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q, err_d;

    logic req0, req1, granted, gnt_id, sel_read, sel_write, own_req, other_req;
    logic fifo_full, fifo_empty, blk, accept, push, pop, head_id;

    assign req0       = m0_read | m0_write;
    assign req1       = m1_read | m1_write;
    assign granted    = (state_q != IDLE) & ~reset_reset;
    assign gnt_id     = (state_q == GNT1);
    assign sel_read   = gnt_id ? m1_read  : m0_read;
    assign sel_write  = gnt_id ? m1_write : m0_write;
    assign own_req    = sel_read | sel_write;
    assign other_req  = gnt_id ? req0 : req1;
    assign fifo_full  = (cnt_q == CNT_W'(MAX_PEND));
    assign fifo_empty = (cnt_q == '0);
    assign blk        = granted & sel_read & fifo_full;
    assign accept     = granted & own_req & ~avm_waitrequest & ~blk;
    assign push       = accept & sel_read;
    assign pop        = avm_readdatavalid & ~fifo_empty & ~reset_reset;
    assign head_id    = tag_q[rd_ptr_q];

    assign avm_address    = gnt_id ? m1_address    : m0_address;
    assign avm_writedata  = gnt_id ? m1_writedata  : m0_writedata;
    assign avm_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
    // A simultaneous read+write is illegal; only the read is forwarded.
    assign avm_read       = granted & sel_read & ~blk;
    assign avm_write      = granted & sel_write & ~sel_read;

    assign m0_waitrequest   = (granted & ~gnt_id) ? (avm_waitrequest | blk) : 1'b1;
    assign m1_waitrequest   = (granted &  gnt_id) ? (avm_waitrequest | blk) : 1'b1;
    assign m0_readdata      = avm_readdata;
    assign m1_readdata      = avm_readdata;
    assign m0_readdatavalid = pop & ~head_id;
    assign m1_readdatavalid = pop &  head_id;
    assign err_o            = err_q;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        err_d      = err_q | (avm_readdatavalid & fifo_empty) | (granted & sel_read & sel_write);
        case (state_q)
            IDLE: begin
                if (req0 | req1)
                    state_d = (req1 & (~req0 | ~last_gnt_q)) ? GNT1 : GNT0;
            end
            GNT0, GNT1: begin
                if (accept) begin
                    last_gnt_d = gnt_id;
                    if (other_req)
                        state_d = gnt_id ? GNT0 : GNT1;
                end else if (!own_req) begin
                    state_d = other_req ? (gnt_id ? GNT0 : GNT1) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            if (push) begin
                tag_q[wr_ptr_q] <= gnt_id;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push & ~pop)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (pop & ~push)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: inputs change 1 time unit after the rising edge,
// outputs are checked 1 unit later, with hand-computed expectations.
module tb_sdram_port_arbiter;
    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [31:0] m0_address, m1_address, avm_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, avm_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, avm_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, avm_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_port_arbiter dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .err_o(err_o)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
    endtask

    initial begin
        reset_reset = 1'b1;
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 4'hF;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 4'hF;
        avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
        tick();
        m0_write = 1;
        #1;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_avm_write", avm_write, 0);
        tick();
        reset_reset = 0; m0_write = 0;
        #1;
        chk("idle_avm_read", avm_read, 0);
        chk("idle_err", err_o, 0);

        // Single write from m0
        m0_write = 1; m0_address = 32'h100; m0_writedata = 32'hCAFE;
        #1;
        chk("w1_arb_wait", m0_waitrequest, 1);
        chk("w1_arb_write", avm_write, 0);
        tick();
        #1;
        chk("w1_avm_write", avm_write, 1);
        chk("w1_avm_addr", avm_address, 32'h100);
        chk("w1_avm_data", avm_writedata, 32'hCAFE);
        chk("w1_m0_wait", m0_waitrequest, 0);
        chk("w1_m1_wait", m1_waitrequest, 1);
        tick();
        m0_write = 0;
        #1;
        chk("w1_done_write", avm_write, 0);
        tick();

        // Both requesters write continuously: grants alternate 0,1,0,1
        do_reset();
        m0_write = 1; m0_address = 32'h200; m1_write = 1; m1_address = 32'h300;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_m0_wait", k), m0_waitrequest, (k % 2 == 0) ? 0 : 1);
            chk($sformatf("rr%0d_m1_wait", k), m1_waitrequest, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_addr", k), avm_address, (k % 2 == 0) ? 32'h200 : 32'h300);
            tick();
        end
        m0_write = 0; m1_write = 0;
        tick();

        // m1 read stalled by the shared port for 3 cycles while m0 waits
        do_reset();
        m1_read = 1; m1_address = 32'h400; avm_waitrequest = 1;
        tick();
        m0_write = 1; m0_address = 32'h500;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("ws%0d_read", k), avm_read, 1);
            chk($sformatf("ws%0d_addr", k), avm_address, 32'h400);
            chk($sformatf("ws%0d_m1_wait", k), m1_waitrequest, 1);
            chk($sformatf("ws%0d_m0_wait", k), m0_waitrequest, 1);
            tick();
        end
        avm_waitrequest = 0;
        #1;
        chk("ws_rel_m1_wait", m1_waitrequest, 0);
        chk("ws_rel_m0_wait", m0_waitrequest, 1);
        tick();
        m1_read = 0;
        #1;
        chk("ws_m0_gnt_write", avm_write, 1);
        chk("ws_m0_gnt_addr", avm_address, 32'h500);
        tick();
        m0_write = 0; avm_readdatavalid = 1; avm_readdata = 32'h55;
        #1;
        chk("ws_pop_m1_rdv", m1_readdatavalid, 1);
        chk("ws_pop_m0_rdv", m0_readdatavalid, 0);
        chk("ws_pop_data", m1_readdata, 32'h55);
        tick();
        avm_readdatavalid = 0;

        // Four tagged reads m0,m1,m1,m0, a fifth blocked until the first pop
        do_reset();
        m0_read = 1; m0_address = 32'h10;
        tick();
        m1_read = 1; m1_address = 32'h20;
        #1;
        chk("rd1_read", avm_read, 1);
        chk("rd1_m0_wait", m0_waitrequest, 0);
        tick();
        m0_read = 0;
        #1;
        chk("rd2_addr", avm_address, 32'h20);
        chk("rd2_m1_wait", m1_waitrequest, 0);
        tick();
        m1_address = 32'h24; m0_read = 1; m0_address = 32'h14;
        #1;
        chk("rd3_addr", avm_address, 32'h24);
        tick();
        m1_read = 0;
        #1;
        chk("rd4_addr", avm_address, 32'h14);
        chk("rd4_m0_wait", m0_waitrequest, 0);
        tick();
        m0_address = 32'h18;
        #1;
        chk("rd5_blk_read", avm_read, 0);
        chk("rd5_blk_wait", m0_waitrequest, 1);
        tick();
        avm_readdatavalid = 1; avm_readdata = 32'hA0;
        #1;
        chk("pop1_m0_rdv", m0_readdatavalid, 1);
        chk("pop1_m1_rdv", m1_readdatavalid, 0);
        chk("pop1_data", m0_readdata, 32'hA0);
        chk("pop1_still_blk", avm_read, 0);
        chk("pop1_still_wait", m0_waitrequest, 1);
        tick();
        avm_readdata = 32'hA1;
        #1;
        chk("pop2_m1_rdv", m1_readdatavalid, 1);
        chk("pop2_m0_rdv", m0_readdatavalid, 0);
        chk("rd5_unblk_read", avm_read, 1);
        chk("rd5_unblk_addr", avm_address, 32'h18);
        chk("rd5_unblk_wait", m0_waitrequest, 0);
        tick();
        m0_read = 0; avm_readdata = 32'hA2;
        #1;
        chk("pop3_m1_rdv", m1_readdatavalid, 1);
        chk("pop3_data", m1_readdata, 32'hA2);
        tick();
        avm_readdata = 32'hA3;
        #1;
        chk("pop4_m0_rdv", m0_readdatavalid, 1);
        chk("pop4_m1_rdv", m1_readdatavalid, 0);
        tick();
        avm_readdata = 32'hA4;
        #1;
        chk("pop5_m0_rdv", m0_readdatavalid, 1);
        chk("pop5_err", err_o, 0);
        tick();

        // Readdatavalid with nothing outstanding
        #1;
        chk("empty_m0_rdv", m0_readdatavalid, 0);
        chk("empty_m1_rdv", m1_readdatavalid, 0);
        tick();
        avm_readdatavalid = 0;
        #1;
        chk("empty_err_set", err_o, 1);
        tick();
        tick();
        chk("empty_err_sticky", err_o, 1);
        do_reset();
        #1;
        chk("err_cleared", err_o, 0);

        // Reset with two reads outstanding
        m0_read = 1; m0_address = 32'h40;
        tick();
        tick();
        m0_address = 32'h44;
        tick();
        reset_reset = 1;
        #1;
        chk("mid_rst_read", avm_read, 0);
        chk("mid_rst_m0_wait", m0_waitrequest, 1);
        tick();
        reset_reset = 0; m0_read = 0;
        #1;
        chk("post_rst_m0_wait", m0_waitrequest, 1);
        chk("post_rst_m1_wait", m1_waitrequest, 1);
        avm_readdatavalid = 1;
        #1;
        chk("late_m0_rdv", m0_readdatavalid, 0);
        chk("late_m1_rdv", m1_readdatavalid, 0);
        tick();
        avm_readdatavalid = 0;
        #1;
        chk("late_err", err_o, 1);

        // Illegal simultaneous read and write: read forwarded, error flagged
        do_reset();
        m1_read = 1; m1_write = 1; m1_address = 32'h60;
        tick();
        #1;
        chk("ill_read", avm_read, 1);
        chk("ill_write", avm_write, 0);
        tick();
        m1_read = 0; m1_write = 0;
        #1;
        chk("ill_err", err_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
